// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
//   Groups the request/response handshake and the ALU-facing bus of the ALU
//   sequencer.
//
//   Handshake (valid/ready): a request is accepted on a rising clock edge
//   where start=1 and ready=1. With ready=0, start is ignored and nothing
//   is queued. done is a one-cycle pulse. z/hi/lo/div_zero/illegal_op
//   belong to the completed op and hold until the next accept.
//
//   Request side : start, op, a, b -> ready, done, z, hi, lo, div_zero,
//                  illegal_op
//   ALU side     : alu_a, alu_b, alu_select -> alu_z, alu_hi, alu_lo,
//                  alu_divide_by_zero
//
//   slave  : the sequencer
//   master : datapath control plus the ALU (testbench)
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int OP_BITS = 4
);
    logic               start;
    logic [OP_BITS-1:0] op;
    logic [31:0]        a;
    logic [31:0]        b;
    logic               ready;
    logic               done;
    logic [31:0]        z;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic               div_zero;
    logic               illegal_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [11:0]        alu_select;
    logic [31:0]        alu_z;
    logic [31:0]        alu_hi;
    logic [31:0]        alu_lo;
    logic               alu_divide_by_zero;

    modport slave (
        input  start, op, a, b, alu_z, alu_hi, alu_lo, alu_divide_by_zero,
        output ready, done, z, hi, lo, div_zero, illegal_op,
               alu_a, alu_b, alu_select
    );

    modport master (
        output start, op, a, b, alu_z, alu_hi, alu_lo, alu_divide_by_zero,
        input  ready, done, z, hi, lo, div_zero, illegal_op,
               alu_a, alu_b, alu_select
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Control stage directly upstream of the ALU. It accepts an encoded op and
//   its operands and drives the ALU one-hot select for the op's latency:
//   one cycle for combinational ops and DIV_CYCLES cycles for divide. It
//   then captures z/hi/lo and reports completion and exceptions.
//
//   Ports:
//     clk     : rising-edge clock
//     clr     : synchronous active-high reset; it wins over start
//     bus     : alu_sequencer_if.slave (request handshake + ALU bus)
//     state_o : current FSM state (0 IDLE, 1 EXEC, 2 DIV_WAIT, 3 DONE)
//
//   Parameters:
//     DIV_CYCLES : cycles select[9] is held before the divide result is
//                  captured. Must be >= 2.
//     OP_BITS    : width of the encoded op
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DIV_CYCLES = 33,
    parameter int OP_BITS    = 4
) (
    input  logic             clk,
    input  logic             clr,
    alu_sequencer_if.slave   bus,
    output logic [1:0]       state_o
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [31:0]        z_q, z_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               div_zero_q, div_zero_d;
    logic               illegal_q, illegal_d;

    logic ready;
    logic op_illegal;
    logic op_is_div;
    logic sel_active;

    assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
    assign op_illegal = (32'(bus.op) > 32'd11);
    assign op_is_div  = (32'(bus.op) == 32'd9);
    // Select is 0 in IDLE and DONE. This gives every divide a fresh rising
    // edge on select[9], even when two divides run back to back.
    assign sel_active = (state_q == S_EXEC) || (state_q == S_DIV_WAIT);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            z_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            z_q        <= z_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        z_d        = z_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    op_d       = bus.op;
                    alu_a_d    = bus.a;
                    alu_b_d    = bus.b;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    cnt_d      = '0;
                    if (op_illegal) begin
                        // The ALU is never selected. Results are forced to 0.
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                        z_d       = '0;
                        hi_d      = '0;
                        lo_d      = '0;
                    end else if (op_is_div && (bus.b == 32'd0)) begin
                        state_d    = S_DONE;
                        div_zero_d = 1'b1;
                        z_d        = '0;
                        hi_d       = '0;
                        lo_d       = '0;
                    end else if (op_is_div) begin
                        state_d = S_DIV_WAIT;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                z_d     = bus.alu_z;
                hi_d    = bus.alu_hi;
                lo_d    = bus.alu_lo;
                state_d = S_DONE;
            end
            S_DIV_WAIT: begin
                // cnt_q equals the number of cycles select[9] has been high,
                // counting the current cycle.
                if (cnt_q == CW'(DIV_CYCLES)) begin
                    z_d        = bus.alu_z;
                    hi_d       = bus.alu_hi;
                    lo_d       = bus.alu_lo;
                    div_zero_d = bus.alu_divide_by_zero;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.alu_select = '0;
        for (int i = 0; i < 12; i++) begin
            bus.alu_select[i] = sel_active && (32'(op_q) == i);
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = (state_q == S_DONE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.z          = z_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.illegal_op = illegal_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer. A behavioural ALU answers the select lines; the
//   divide result becomes valid only after select[9] has been high for
//   DIV_CYCLES cycles. A scoreboard holds the expected {z,hi,lo,div_zero,
//   illegal_op} per accepted op and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    localparam int DIV_CYCLES = 33;
    localparam int EW = 98;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] state;
    int         check_cnt = 0;
    int         pass_cnt = 0;
    int         div_cnt = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_sequencer_if #(.OP_BITS(4)) bus ();

    alu_sequencer #(.DIV_CYCLES(DIV_CYCLES), .OP_BITS(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus),
        .state_o (state)
    );

    // ---------------- behavioural ALU ----------------
    logic [63:0] mul_p, ror_w, rol_w;
    assign mul_p = 64'(bus.alu_a) * 64'(bus.alu_b);
    assign ror_w = {bus.alu_a, bus.alu_a} >> bus.alu_b[4:0];
    assign rol_w = {bus.alu_a, bus.alu_a} << bus.alu_b[4:0];

    always @(posedge clk) div_cnt <= bus.alu_select[9] ? div_cnt + 1 : 0;

    always_comb begin
        bus.alu_z = '0;
        bus.alu_hi = '0;
        bus.alu_lo = '0;
        bus.alu_divide_by_zero = 1'b0;
        if (bus.alu_select[0]) bus.alu_z = bus.alu_a + bus.alu_b;
        if (bus.alu_select[1]) bus.alu_z = bus.alu_a - bus.alu_b;
        if (bus.alu_select[2]) bus.alu_z = bus.alu_a >> bus.alu_b[4:0];
        if (bus.alu_select[3]) bus.alu_z = bus.alu_a << bus.alu_b[4:0];
        if (bus.alu_select[4]) bus.alu_z = ror_w[31:0];
        if (bus.alu_select[5]) bus.alu_z = rol_w[63:32];
        if (bus.alu_select[6]) bus.alu_z = bus.alu_a & bus.alu_b;
        if (bus.alu_select[7]) bus.alu_z = bus.alu_a | bus.alu_b;
        if (bus.alu_select[8]) begin
            bus.alu_hi = mul_p[63:32];
            bus.alu_lo = mul_p[31:0];
            bus.alu_z  = mul_p[31:0];
        end
        if (bus.alu_select[9]) begin
            if (div_cnt < DIV_CYCLES - 1) begin
                bus.alu_z  = 32'hDEAD_BEEF;
                bus.alu_hi = 32'hDEAD_BEEF;
                bus.alu_lo = 32'hDEAD_BEEF;
            end else if (bus.alu_b == 32'd0) begin
                bus.alu_divide_by_zero = 1'b1;
            end else begin
                bus.alu_z  = bus.alu_a / bus.alu_b;
                bus.alu_lo = bus.alu_a / bus.alu_b;
                bus.alu_hi = bus.alu_a % bus.alu_b;
            end
        end
        if (bus.alu_select[10]) bus.alu_z = -bus.alu_a;
        if (bus.alu_select[11]) bus.alu_z = ~bus.alu_a;
    end

    // Reference result of one op: {z, hi, lo, div_zero, illegal_op}
    function automatic logic [EW-1:0] exp_of(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] ez, eh, el;
        logic        ed, ei;
        logic [63:0] p;
        int          s;
        ez = '0; eh = '0; el = '0; ed = 1'b0; ei = 1'b0;
        s = int'(bv[4:0]);
        case (o)
            4'd0: ez = av + bv;
            4'd1: ez = av - bv;
            4'd2: ez = av >> s;
            4'd3: ez = av << s;
            4'd4: ez = (av >> s) | (av << (32 - s));
            4'd5: ez = (av << s) | (av >> (32 - s));
            4'd6: ez = av & bv;
            4'd7: ez = av | bv;
            4'd8: begin p = 64'(av) * 64'(bv); eh = p[63:32]; el = p[31:0]; ez = p[31:0]; end
            4'd9: begin
                if (bv == 0) ed = 1'b1;
                else begin ez = av / bv; el = av / bv; eh = av % bv; end
            end
            4'd10: ez = 32'd0 - av;
            4'd11: ez = ~av;
            default: ei = 1'b1;
        endcase
        return {ez, eh, el, ed, ei};
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [31:0] bv);
        if (o > 4'd11) return 0;
        if (o == 4'd9) return (bv == 0) ? 0 : DIV_CYCLES;
        return 1;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL sb_unexpected_done: done=1 with empty expected queue at %0t", $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check_cnt++;
                if (bus.z !== e[97:66]) $display("FAIL sb_z: got %h want %h", bus.z, e[97:66]); else pass_cnt++;
                check_cnt++;
                if (bus.hi !== e[65:34]) $display("FAIL sb_hi: got %h want %h", bus.hi, e[65:34]); else pass_cnt++;
                check_cnt++;
                if (bus.lo !== e[33:2]) $display("FAIL sb_lo: got %h want %h", bus.lo, e[33:2]); else pass_cnt++;
                check_cnt++;
                if (bus.div_zero !== e[1]) $display("FAIL sb_div_zero: got %b want %b", bus.div_zero, e[1]); else pass_cnt++;
                check_cnt++;
                if (bus.illegal_op !== e[0]) $display("FAIL sb_illegal_op: got %b want %b", bus.illegal_op, e[0]); else pass_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one op from an idle sequencer and measures it: cycles from the
    // accept edge to done, number of cycles select was nonzero, OR of all
    // select values seen, and done one cycle after the pulse.
    task automatic drive_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                            output int lat, output int sel_cnt, output logic [11:0] sel_seen,
                            output logic done_after);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        exp_q.push_back(exp_of(o, av, bv));
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        lat = 0; sel_cnt = 0; sel_seen = '0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.alu_select != 0) sel_cnt++;
            sel_seen |= bus.alu_select;
            @(negedge clk);
            lat++;
        end
        if (bus.alu_select != 0) sel_cnt++;
        sel_seen |= bus.alu_select;
        @(negedge clk);
        done_after = bus.done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.alu_select !== 12'd0 || state !== 2'd0)
            $display("FAIL reset_ctrl: ready=%b done=%b sel=%h state=%0d want 1 0 000 0", bus.ready, bus.done, bus.alu_select, state);
        else pass_cnt++;
        check_cnt++;
        if ({bus.z, bus.hi, bus.lo, bus.alu_a, bus.alu_b} !== 160'd0 || bus.div_zero !== 1'b0 || bus.illegal_op !== 1'b0)
            $display("FAIL reset_data: z=%h hi=%h lo=%h a=%h b=%h dz=%b ill=%b want all 0", bus.z, bus.hi, bus.lo, bus.alu_a, bus.alu_b, bus.div_zero, bus.illegal_op);
        else pass_cnt++;
        // clr and start together: clr wins, nothing accepted
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd1; bus.b = 32'd2; clr = 1'b1;
        @(negedge clk); bus.start = 1'b0; clr = 1'b0;
        check_cnt++;
        if (state !== 2'd0 || bus.alu_a !== 32'd0 || bus.alu_select !== 12'd0)
            $display("FAIL clr_wins: state=%0d alu_a=%h sel=%h want 0 0 000", state, bus.alu_a, bus.alu_select);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_add();
        int lat, sc; logic [11:0] ss; logic da;
        drive_op(4'd0, 32'd124, 32'd7, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 1 || sc !== 1 || ss !== 12'h001)
            $display("FAIL add_timing: lat=%0d selcyc=%0d sel=%h want 1 1 001", lat, sc, ss);
        else pass_cnt++;
        check_cnt++;
        if (bus.z !== 32'd131 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || da !== 1'b0)
            $display("FAIL add_result: z=%0d hi=%0d lo=%0d done_after=%b want 131 0 0 0", bus.z, bus.hi, bus.lo, da);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat, sc; logic [11:0] ss; logic da;
        drive_op(4'd8, 32'd124, 32'd7, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 1 || sc !== 1 || ss !== 12'h100)
            $display("FAIL mul_timing: lat=%0d selcyc=%0d sel=%h want 1 1 100", lat, sc, ss);
        else pass_cnt++;
        check_cnt++;
        if (bus.lo !== 32'd868 || bus.hi !== 32'd0)
            $display("FAIL mul_result: lo=%0d hi=%0d want 868 0", bus.lo, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int lat, sc; logic [11:0] ss; logic da;
        drive_op(4'd9, 32'd100, 32'd7, lat, sc, ss, da);
        check_cnt++;
        if (lat !== DIV_CYCLES || sc !== DIV_CYCLES || ss !== 12'h200)
            $display("FAIL div_timing: lat=%0d selcyc=%0d sel=%h want %0d %0d 200", lat, sc, ss, DIV_CYCLES, DIV_CYCLES);
        else pass_cnt++;
        check_cnt++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.div_zero !== 1'b0 || da !== 1'b0)
            $display("FAIL div_result: lo=%0d hi=%0d dz=%b done_after=%b want 14 2 0 0", bus.lo, bus.hi, bus.div_zero, da);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, sc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd9; bus.a = 32'd1000; bus.b = 32'd13;
        exp_q.push_back(exp_of(4'd9, 32'd1000, 32'd13));
        @(negedge clk);
        // start stays high; these operands must be ignored until DONE
        bus.a = 32'd77777; bus.b = 32'd100;
        exp_q.push_back(exp_of(4'd9, 32'd77777, 32'd100));
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        check_cnt++;
        if (lat !== DIV_CYCLES || bus.alu_select !== 12'd0 || bus.ready !== 1'b1)
            $display("FAIL b2b_first: lat=%0d sel=%h ready=%b want %0d 000 1", lat, bus.alu_select, bus.ready, DIV_CYCLES);
        else pass_cnt++;
        @(negedge clk);
        bus.start = 1'b0;
        check_cnt++;
        if (state !== 2'd2 || bus.alu_select !== 12'h200 || bus.done !== 1'b0)
            $display("FAIL b2b_second_start: state=%0d sel=%h done=%b want 2 200 0", state, bus.alu_select, bus.done);
        else pass_cnt++;
        lat = 0; sc = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.alu_select != 0) sc++;
            @(negedge clk);
            lat++;
        end
        check_cnt++;
        if (lat !== DIV_CYCLES || sc !== DIV_CYCLES || bus.lo !== 32'd777 || bus.hi !== 32'd77)
            $display("FAIL b2b_second: lat=%0d selcyc=%0d lo=%0d hi=%0d want %0d %0d 777 77", lat, sc, bus.lo, bus.hi, DIV_CYCLES, DIV_CYCLES);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, sc; logic [11:0] ss; logic da;
        drive_op(4'd9, 32'd55, 32'd0, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 0 || sc !== 0 || ss !== 12'd0)
            $display("FAIL divz_timing: lat=%0d selcyc=%0d sel=%h want 0 0 000", lat, sc, ss);
        else pass_cnt++;
        check_cnt++;
        if (bus.div_zero !== 1'b1 || {bus.z, bus.hi, bus.lo} !== 96'd0 || da !== 1'b0)
            $display("FAIL divz_result: dz=%b z=%h hi=%h lo=%h done_after=%b want 1 0 0 0 0", bus.div_zero, bus.z, bus.hi, bus.lo, da);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int lat, sc; logic [11:0] ss; logic da;
        drive_op(4'hC, 32'd5, 32'd6, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 0 || sc !== 0 || bus.illegal_op !== 1'b1 || bus.div_zero !== 1'b0)
            $display("FAIL illegal_c: lat=%0d selcyc=%0d ill=%b dz=%b want 0 0 1 0", lat, sc, bus.illegal_op, bus.div_zero);
        else pass_cnt++;
        drive_op(4'hF, 32'd9, 32'd9, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 0 || ss !== 12'd0 || bus.illegal_op !== 1'b1)
            $display("FAIL illegal_f: lat=%0d sel=%h ill=%b want 0 000 1", lat, ss, bus.illegal_op);
        else pass_cnt++;
        drive_op(4'hA, 32'd124, 32'd0, lat, sc, ss, da);
        check_cnt++;
        if (bus.z !== 32'hFFFF_FF84 || bus.illegal_op !== 1'b0 || ss !== 12'h400)
            $display("FAIL neg: z=%h ill=%b sel=%h want ffffff84 0 400", bus.z, bus.illegal_op, ss);
        else pass_cnt++;
    endtask

    task automatic test_clr_mid_div();
        int lat, sc, dones; logic [11:0] ss; logic da;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd9; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_cnt++;
        if (state !== 2'd2 || bus.alu_select !== 12'h200)
            $display("FAIL clr_div_running: state=%0d sel=%h want 2 200", state, bus.alu_select);
        else pass_cnt++;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_cnt++;
        if (bus.alu_select !== 12'd0 || state !== 2'd0 || bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL clr_div_ctrl: sel=%h state=%0d ready=%b done=%b want 000 0 1 0", bus.alu_select, state, bus.ready, bus.done);
        else pass_cnt++;
        check_cnt++;
        if ({bus.z, bus.hi, bus.lo, bus.alu_a, bus.alu_b} !== 160'd0 || bus.div_zero !== 1'b0 || bus.illegal_op !== 1'b0)
            $display("FAIL clr_div_data: z=%h hi=%h lo=%h a=%h b=%h want all 0", bus.z, bus.hi, bus.lo, bus.alu_a, bus.alu_b);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check_cnt++;
        if (dones !== 0) $display("FAIL clr_div_no_done: got %0d done cycles want 0", dones);
        else pass_cnt++;
        drive_op(4'd0, 32'd3, 32'd4, lat, sc, ss, da);
        check_cnt++;
        if (lat !== 1 || bus.z !== 32'd7)
            $display("FAIL clr_div_add_after: lat=%0d z=%0d want 1 7", lat, bus.z);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, sc; logic [11:0] ss; logic da;
        logic [3:0] o; logic [31:0] av, bv;
        for (int n = 0; n < 24; n++) begin
            o = 4'($urandom_range(0, 15));
            av = $urandom;
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            drive_op(o, av, bv, lat, sc, ss, da);
            check_cnt++;
            if (lat !== exp_lat(o, bv) || sc !== exp_lat(o, bv) || da !== 1'b0)
                $display("FAIL rand_timing op=%0d: lat=%0d selcyc=%0d done_after=%b want %0d %0d 0", o, lat, sc, da, exp_lat(o, bv), exp_lat(o, bv));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_back_to_back();
        test_div_zero();
        test_illegal();
        test_clr_mid_div();
        test_random();
        repeat (2) @(negedge clk);
        check_cnt++;
        if (exp_q.size() !== 0) $display("FAIL sb_leftover: %0d entries never completed, want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
